return_addr_stack: RTL and testbench

- Hardware call/return address stack for the multicycle MUSA core.
- Responder side of the control unit's push/pop interface: CALL pushes the return PC, RET pops it.
- Sits beside the PC-select logic. The top-of-stack value feeds the RET path of the PC source mux.
- Circular LIFO with overflow and underflow detection, and a strobe-qualified handshake so that each instruction performs exactly one operation.

---
 rtl/musa_pkg.sv | 26 ++
 rtl/return_addr_stack.sv | 99 +++++++++
 tb/tb_return_addr_stack.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/musa_pkg.sv
// Shared MUSA core definitions: datapath width, return-stack depth and the
// push/pop operation encoding used by control decode and the return stack.
package musa_pkg;

   localparam int unsigned MUSA_ADDR_WIDTH = 32;
   localparam int unsigned RAS_DEPTH       = 8;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_REPLACE
   } stack_op_t;

   function automatic stack_op_t decode_op(input logic push, input logic pop);
      stack_op_t op;
      case ({push, pop})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_REPLACE;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular call/return address stack. One operation per rising strobe edge;
// top_data is driven from registered state only.
module return_addr_stack
   import musa_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH = MUSA_ADDR_WIDTH,
   parameter  int unsigned DEPTH      = RAS_DEPTH,
   localparam int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  strobe,
   input  logic [ADDR_WIDTH-1:0] push_data,
   input  logic                  clear_err,
   output logic [ADDR_WIDTH-1:0] top_data,
   output logic [PTR_WIDTH:0]    count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [PTR_WIDTH:0] COUNT_MAX = (PTR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]  ptr;
   logic [PTR_WIDTH-1:0]  ptr_inc;
   logic [PTR_WIDTH-1:0]  ptr_dec;
   logic [PTR_WIDTH-1:0]  wr_addr;
   logic                  wr_en;
   logic                  strobe_q;
   logic                  fire;
   stack_op_t             op;

   assign fire    = strobe & ~strobe_q;
   assign ptr_inc = ptr + PTR_WIDTH'(1);
   assign ptr_dec = ptr - PTR_WIDTH'(1);
   assign empty   = (count == '0);
   assign full    = (count == COUNT_MAX);

   // A replace on an empty stack has no top to overwrite, so it degrades to a push.
   always_comb begin
      op = decode_op(push, pop);
      if (op == OP_REPLACE && empty)
         op = OP_PUSH;
   end

   always_comb begin
      wr_en   = fire && (op == OP_PUSH || op == OP_REPLACE);
      wr_addr = (op == OP_REPLACE) ? ptr : ptr_inc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         count     <= '0;
         strobe_q  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         strobe_q <= strobe;
         if (clear_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         // Set events below are assigned later, so they win over clear_err.
         if (fire) begin
            case (op)
               OP_PUSH: begin
                  ptr <= ptr_inc;
                  if (full)
                     overflow <= 1'b1;
                  else
                     count <= count + (PTR_WIDTH+1)'(1);
               end
               OP_POP: begin
                  if (empty) begin
                     underflow <= 1'b1;
                  end else begin
                     ptr   <= ptr_dec;
                     count <= count - (PTR_WIDTH+1)'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= push_data;
   end

   assign top_data = empty ? '0 : mem[ptr];

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed checks of return_addr_stack at DEPTH=4 with hand-computed expectations.
module tb_return_addr_stack;

   logic        clk;
   logic        reset;
   logic        push;
   logic        pop;
   logic        strobe;
   logic [31:0] push_data;
   logic        clear_err;
   logic [31:0] top_data;
   logic [2:0]  count;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        underflow;

   int unsigned n_total;
   int unsigned n_pass;

   return_addr_stack #(.ADDR_WIDTH(32), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .strobe    (strobe),
      .push_data (push_data),
      .clear_err (clear_err),
      .top_data  (top_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic check_state(input string tag, input logic [31:0] e_top, input logic [31:0] e_count,
                              input logic e_ovf, input logic e_unf);
      check({tag, ".top"},   top_data, e_top);
      check({tag, ".count"}, 32'(count), e_count);
      check({tag, ".empty"}, 32'(empty), 32'(e_count == 0));
      check({tag, ".full"},  32'(full),  32'(e_count == 4));
      check({tag, ".ovf"},   32'(overflow),  32'(e_ovf));
      check({tag, ".unf"},   32'(underflow), 32'(e_unf));
   endtask

   // One-cycle strobe pulse; state is stable at the following negedge.
   task automatic op(input logic p_push, input logic p_pop, input logic [31:0] data, input logic clr);
      @(negedge clk);
      strobe    = 1'b1;
      push      = p_push;
      pop       = p_pop;
      push_data = data;
      clear_err = clr;
      @(negedge clk);
      strobe    = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      clear_err = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
   endtask

   initial begin
      n_total   = 0;
      n_pass    = 0;
      reset     = 1'b1;
      push      = 1'b0;
      pop       = 1'b0;
      strobe    = 1'b0;
      push_data = '0;
      clear_err = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_state("reset", 32'h0, 0, 1'b0, 1'b0);

      // LIFO order
      op(1'b1, 1'b0, 32'h10, 1'b0);
      check_state("push10", 32'h10, 1, 1'b0, 1'b0);
      op(1'b1, 1'b0, 32'h20, 1'b0);
      op(1'b1, 1'b0, 32'h30, 1'b0);
      check_state("push30", 32'h30, 3, 1'b0, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("pop1", 32'h20, 2, 1'b0, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("pop2", 32'h10, 1, 1'b0, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("pop3", 32'h0, 0, 1'b0, 1'b0);

      // Long strobe gives a single push
      @(negedge clk);
      strobe    = 1'b1;
      push      = 1'b1;
      push_data = 32'h44;
      repeat (3) @(negedge clk);
      strobe = 1'b0;
      push   = 1'b0;
      @(negedge clk);
      check_state("hold", 32'h44, 1, 1'b0, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("hold_pop", 32'h0, 0, 1'b0, 1'b0);

      // Overflow with circular overwrite
      op(1'b1, 1'b0, 32'hA, 1'b0);
      op(1'b1, 1'b0, 32'hB, 1'b0);
      op(1'b1, 1'b0, 32'hC, 1'b0);
      op(1'b1, 1'b0, 32'hD, 1'b0);
      check_state("fullD", 32'hD, 4, 1'b0, 1'b0);
      op(1'b1, 1'b0, 32'hE, 1'b0);
      check_state("ovfE", 32'hE, 4, 1'b1, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("wpop1", 32'hD, 3, 1'b1, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("wpop2", 32'hC, 2, 1'b1, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("wpop3", 32'hB, 1, 1'b1, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("wpop4", 32'h0, 0, 1'b1, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("wpop5", 32'h0, 0, 1'b1, 1'b1);
      pulse_clear();
      check_state("clr1", 32'h0, 0, 1'b0, 1'b0);

      // Underflow, clear, and set-beats-clear
      op(1'b0, 1'b1, 32'h0, 1'b0);
      check_state("unf", 32'h0, 0, 1'b0, 1'b1);
      pulse_clear();
      check_state("clr2", 32'h0, 0, 1'b0, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b1);
      check_state("setwins", 32'h0, 0, 1'b0, 1'b1);
      pulse_clear();

      // Replace top, and replace on empty acting as push
      op(1'b1, 1'b0, 32'h100, 1'b0);
      op(1'b1, 1'b1, 32'h200, 1'b0);
      check_state("replace", 32'h200, 1, 1'b0, 1'b0);
      op(1'b0, 1'b1, 32'h0, 1'b0);
      op(1'b1, 1'b1, 32'h300, 1'b0);
      check_state("repl_empty", 32'h300, 1, 1'b0, 1'b0);

      // Async reset in the middle of a push
      op(1'b1, 1'b0, 32'h400, 1'b0);
      @(negedge clk);
      strobe    = 1'b1;
      push      = 1'b1;
      push_data = 32'h55;
      #2 reset = 1'b1;
      #1;
      check_state("midrst", 32'h0, 0, 1'b0, 1'b0);
      @(negedge clk);
      strobe = 1'b0;
      push   = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
      check_state("postrst", 32'h0, 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
